// File: rtl/btc_enc_src_arb.sv
// Round-robin scheduler sharing one btc_enc_engine between pN_SRC ping-pong input buffers.
// Define BTC_ENC_ARB_FIXED_PRIO_EN for strict priority (source 0 highest) instead of round-robin.
module btc_enc_src_arb #(
  parameter int pN_SRC   = 4,
  parameter int pTAG_W   = 8,
  parameter int pMODE_W  = 2,  // width of btc_code_mode_t
  parameter int pSMODE_W = 2,  // width of btc_short_mode_t
  parameter int pSEL_W   = (pN_SRC > 1) ? $clog2(pN_SRC) : 1
) (
  input  logic                               iclk,
  input  logic                               ireset,
  input  logic                               iclkena,
  input  logic [pN_SRC-1:0]                  isrc_full,
  input  logic [pN_SRC-1:0][pMODE_W-1:0]     isrc_xmode,
  input  logic [pN_SRC-1:0][pMODE_W-1:0]     isrc_ymode,
  input  logic [pN_SRC-1:0][pSMODE_W-1:0]    isrc_smode,
  input  logic [pN_SRC-1:0][pTAG_W-1:0]      isrc_tag,
  output logic [pN_SRC-1:0]                  osrc_empty,
  output logic                               oeng_rbuf_full,
  input  logic                               ieng_rempty,
  input  logic                               ieng_wfull,
  output logic [pMODE_W-1:0]                 oeng_xmode,
  output logic [pMODE_W-1:0]                 oeng_ymode,
  output logic [pSMODE_W-1:0]                oeng_smode,
  output logic [pTAG_W-1:0]                  oeng_tag,
  output logic [pSEL_W-1:0]                  osel,
  output logic                               obusy
);

  // IDLE: arbitrate | GRANT: engine claimed | READ: engine consumes input | FLUSH: await output | RELEASE: bubble
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    READ    = 3'd2,
    FLUSH   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [pSEL_W-1:0]     last_sel, last_sel_d;
  logic [pSEL_W-1:0]     winner;
  logic [pSEL_W-1:0]     sel_d;
  logic                  rbuf_full_d;
  logic [pN_SRC-1:0]     empty_d;
  logic [pMODE_W-1:0]    xmode_d, ymode_d;
  logic [pSMODE_W-1:0]   smode_d;
  logic [pTAG_W-1:0]     tag_d;

`ifdef BTC_ENC_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = pN_SRC - 1; i >= 0; i--) begin
      if (isrc_full[pSEL_W'(i)]) winner = pSEL_W'(i);
    end
  end
`else
  always_comb begin
    int                idx;
    logic              found;
    logic [pSEL_W-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= pN_SRC; i++) begin
      idx = int'(last_sel) + i;
      if (idx >= pN_SRC) idx = idx - pN_SRC;
      cand = pSEL_W'(idx);
      if (!found && isrc_full[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    last_sel_d  = last_sel;
    sel_d       = osel;
    rbuf_full_d = oeng_rbuf_full;
    empty_d     = '0;
    xmode_d     = oeng_xmode;
    ymode_d     = oeng_ymode;
    smode_d     = oeng_smode;
    tag_d       = oeng_tag;
    case (state_q)
      IDLE: begin
        if (|isrc_full) begin
          sel_d   = winner;
          xmode_d = isrc_xmode[winner];
          ymode_d = isrc_ymode[winner];
          smode_d = isrc_smode[winner];
          tag_d   = isrc_tag[winner];
          state_d = GRANT;
        end
      end
      GRANT: begin
        rbuf_full_d = 1'b1;
        state_d     = READ;
      end
      READ: begin
        if (ieng_rempty) begin
          rbuf_full_d = 1'b0;
          empty_d     = pN_SRC'(1) << osel;
          // a coincident output flush is honoured in the same step
          state_d     = ieng_wfull ? RELEASE : FLUSH;
        end
      end
      FLUSH: begin
        if (ieng_wfull) state_d = RELEASE;
      end
      RELEASE: begin
        last_sel_d = osel;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q        <= IDLE;
      last_sel       <= pSEL_W'(pN_SRC - 1);
      osel           <= '0;
      oeng_rbuf_full <= 1'b0;
      osrc_empty     <= '0;
      oeng_xmode     <= '0;
      oeng_ymode     <= '0;
      oeng_smode     <= '0;
      oeng_tag       <= '0;
    end else if (iclkena) begin
      state_q        <= state_d;
      last_sel       <= last_sel_d;
      osel           <= sel_d;
      oeng_rbuf_full <= rbuf_full_d;
      osrc_empty     <= empty_d;
      oeng_xmode     <= xmode_d;
      oeng_ymode     <= ymode_d;
      oeng_smode     <= smode_d;
      oeng_tag       <= tag_d;
    end
  end

  assign obusy = (state_q == GRANT) || (state_q == READ) || (state_q == FLUSH);

endmodule

// File: doc/btc_enc_src_arb.md
Name: btc_enc_src_arb

Overview:
- Round-robin arbiter/scheduler that shares one btc_enc_engine between pN_SRC independent input ping-pong buffers.
- Each source raises a "buffer full" request carrying its own code modes and tag.
- The arbiter grants the engine to one source per frame, drives the engine's irbuf_full/mode/tag inputs and a read-mux select, and returns the engine's orempty to the granted source.
- Next grant is held off until the engine has flushed the previous frame's output (engine owfull), so mode/tag stay stable for the engine's output-side latching.

Parameters:
- pN_SRC, 4, number of requesting sources (2..8).
- pTAG_W, 8, tag width per source.
- pSEL_W, $clog2(pN_SRC) (min 1), width of source select.

Ports:
- iclk  in  1  clock
- ireset  in  1  async reset, active-high
- iclkena  in  1  clock enable; all state frozen when low
- isrc_full  in  pN_SRC  per-source input buffer full (level, held until its osrc_empty pulse)
- isrc_xmode  in  pN_SRC x btc_code_mode_t  per-source row code mode
- isrc_ymode  in  pN_SRC x btc_code_mode_t  per-source column code mode
- isrc_smode  in  pN_SRC x btc_short_mode_t  per-source shortening mode
- isrc_tag  in  pN_SRC x pTAG_W  per-source frame tag
- osrc_empty  out  pN_SRC  one-hot 1-cycle pulse: granted source's buffer released
- oeng_rbuf_full  out  1  to engine irbuf_full
- ieng_rempty  in  1  from engine orempty (1-cycle pulse, input frame consumed)
- ieng_wfull  in  1  from engine owfull (1-cycle pulse, output frame written)
- oeng_xmode, oeng_ymode  out  btc_code_mode_t  to engine ixmode/iymode
- oeng_smode  out  btc_short_mode_t  to engine ismode
- oeng_tag  out  pTAG_W  to engine irtag
- osel  out  pSEL_W  read-data mux select for the irdat source
- obusy  out  1  engine owned by a source

Behaviour:
- FSM states: IDLE, GRANT, READ, FLUSH, RELEASE. All transitions require iclkena=1.
- IDLE: if any isrc_full bit is set, pick the winner. Round-robin scan starts at (last_sel+1) mod pN_SRC. Register osel and the winner's x/y/s modes and tag onto the oeng_* outputs, then go to GRANT. No request: stay.
- GRANT: oeng_rbuf_full=1, obusy=1. Go to READ.
- READ: oeng_rbuf_full stays 1 until ieng_rempty is seen.
  - On ieng_rempty: drop oeng_rbuf_full, pulse osrc_empty[osel] in the same registered update (visible next cycle), go to FLUSH.
- FLUSH: wait for ieng_wfull, then go to RELEASE.
  - If ieng_wfull arrives in the same cycle as ieng_rempty, both are honoured: READ goes directly to RELEASE.
- RELEASE: obusy=0, last_sel<=osel, go to IDLE. This gives a 1-cycle bubble, so there is no new grant in the same cycle as the release.
- osel and oeng_* mode/tag change only on the IDLE->GRANT transition and hold otherwise, including through RELEASE and IDLE.
- Latency: request seen in IDLE -> oeng_rbuf_full high 2 cycles later.
- Requests from the current owner are ignored until RELEASE.
- isrc_full dropping while granted is a protocol error: ignored, frame completes.
- isrc_full of the granted source re-asserting is re-arbitrated fairly.
- Requests changing in the same cycle as a grant: the sampled value wins.
- ieng_rempty or ieng_wfull outside READ/FLUSH: ignored.
- Reset values: state=IDLE, last_sel=pN_SRC-1 (first scan starts at 0), osel=0, oeng_rbuf_full=0, osrc_empty=0, obusy=0, oeng_xmode/ymode/smode='0, oeng_tag='0.
- Reset mid-frame aborts immediately with the outputs above; no osrc_empty pulse is issued.

Optional Feature:
- BTC_ENC_ARB_FIXED_PRIO_EN defined:
  - Winner is the lowest-index set isrc_full bit (strict priority, source 0 highest).
  - last_sel is still updated but unused.
- Not defined: round-robin as above.

Test Plan:
- Single request: isrc_full=4'b0100 -> osel=2 and oeng_rbuf_full=1 two cycles later. Tag/modes equal source 2 values. After ieng_rempty, osrc_empty=4'b0100 for exactly 1 cycle.
- Fairness: isrc_full=4'b1111 held, each released after rempty+wfull -> grant order 0,1,2,3,0. With BTC_ENC_ARB_FIXED_PRIO_EN the order is 0,0,0.
- Flush hold-off: rempty at cycle t, wfull at t+20, other source requesting -> no new oeng_rbuf_full before t+22. oeng_tag stays constant from t to t+21.
- Coincident pulses: ieng_rempty and ieng_wfull in the same cycle -> state goes READ->RELEASE. osrc_empty pulses once; next grant 2 cycles later.
- Clock enable: iclkena=0 for 5 cycles during READ with ieng_rempty held high -> no state change. Pulse taken on the first iclkena=1 cycle.
- Reset mid-READ: ireset asserted -> all outputs at reset values asynchronously, no osrc_empty. After release, a pending source 3 request is granted, since the scan starts at 0 and finds 3.
